// File: rtl/multi_debouncer.sv
// N-channel button debouncer: 2-FF synchroniser, stability filter, IDLE/PROC/DONE
// press FSM and per-channel press counter for each channel.
module multi_debouncer #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned CNT_WIDTH  = 4,
    parameter int unsigned SATURATE   = 0
) (
    input  logic                      clk_div,
    input  logic                      rst,
    input  logic [N_CH-1:0]           i_btn_in,
    input  logic                      i_clear,
    output logic [N_CH-1:0]           o_db_level,
    output logic [N_CH-1:0]           o_press_pulse,
    output logic [N_CH-1:0]           o_done_sig,
    output logic                      o_any_done,
    output logic [N_CH*CNT_WIDTH-1:0] o_count
);

    localparam int unsigned FW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StProc = 2'b01,
        StDone = 2'b10
    } state_e;

    for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
        logic [1:0]           r_sync;
        logic [FW-1:0]        r_filt;
        logic                 r_db;
        state_e               r_state;
        logic [CNT_WIDTH-1:0] r_cnt;
        logic                 w_s;
        logic                 w_cnt_hold;

        assign w_s        = r_sync[1];
        assign w_cnt_hold = (SATURATE != 0) && (&r_cnt);

        // A level change is accepted only after STABLE_CNT consecutive differing samples.
        always_ff @(posedge clk_div or posedge rst) begin
            if (rst) begin
                r_sync <= 2'b00;
                r_filt <= '0;
                r_db   <= 1'b0;
            end else begin
                r_sync <= {r_sync[0], i_btn_in[g]};
                if (w_s == r_db) begin
                    r_filt <= '0;
                end else if (r_filt == FW'(STABLE_CNT - 1)) begin
                    r_db   <= w_s;
                    r_filt <= '0;
                end else begin
                    r_filt <= r_filt + FW'(1);
                end
            end
        end

        always_ff @(posedge clk_div or posedge rst) begin
            if (rst) begin
                r_state <= StIdle;
            end else begin
                case (r_state)
                    StIdle:  if (r_db) r_state <= StProc;
                    StProc:  r_state <= StDone;
                    StDone:  if (!r_db) r_state <= StIdle;
                    default: r_state <= StIdle;
                endcase
            end
        end

        // Clear wins over a coincident increment, so that press is dropped.
        always_ff @(posedge clk_div or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (i_clear) begin
                r_cnt <= '0;
            end else if ((r_state == StProc) && !w_cnt_hold) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end

        assign o_db_level[g]                       = r_db;
        assign o_press_pulse[g]                    = (r_state == StProc);
        assign o_done_sig[g]                       = (r_state == StDone);
        assign o_count[g*CNT_WIDTH +: CNT_WIDTH]   = r_cnt;
    end

    assign o_any_done = |o_done_sig;

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: directed and random button activity against an
// event-timestamp reference model, on a wrapping and a saturating instance.
module tb_multi_debouncer;

    localparam int N    = 4;
    localparam int ST   = 4;
    localparam int CW   = 4;
    localparam int HMAX = 8192;

    logic          clk_div = 1'b0;
    logic          rst     = 1'b1;
    logic [N-1:0]  btn     = '0;
    logic          clr     = 1'b0;

    logic [N-1:0]    w_db, w_pulse, w_done, s_db, s_pulse, s_done;
    logic            w_any, s_any;
    logic [N*CW-1:0] w_cnt, s_cnt;

    multi_debouncer #(.N_CH(N), .STABLE_CNT(ST), .CNT_WIDTH(CW), .SATURATE(0)) u_dut_wrap (
        .clk_div      (clk_div),
        .rst          (rst),
        .i_btn_in     (btn),
        .i_clear      (clr),
        .o_db_level   (w_db),
        .o_press_pulse(w_pulse),
        .o_done_sig   (w_done),
        .o_any_done   (w_any),
        .o_count      (w_cnt)
    );

    multi_debouncer #(.N_CH(N), .STABLE_CNT(ST), .CNT_WIDTH(CW), .SATURATE(1)) u_dut_sat (
        .clk_div      (clk_div),
        .rst          (rst),
        .i_btn_in     (btn),
        .i_clear      (clr),
        .o_db_level   (s_db),
        .o_press_pulse(s_pulse),
        .o_done_sig   (s_done),
        .o_any_done   (s_any),
        .o_count      (s_cnt)
    );

    always #5 clk_div = ~clk_div;

    // Reference model: per-channel history of sampled inputs plus edge timestamps
    // of the last accepted level change, rise and fall.
    int t;
    bit hist [N][HMAX];
    bit db_m [N];
    int lchg [N];
    int rise [N];
    int fall [N];
    int cw_m [N];
    int cs_m [N];
    int nvec = 0;
    int nerr = 0;
    int runlen [N];

    function automatic void model_reset();
        t = -1;
        for (int c = 0; c < N; c++) begin
            db_m[c] = 1'b0;
            lchg[c] = -1;
            rise[c] = -1000;
            fall[c] = -1000;
            cw_m[c] = 0;
            cs_m[c] = 0;
        end
    endfunction

    function automatic bit s_at(int c, int j);
        return (j >= 2) ? hist[c][j-2] : 1'b0;
    endfunction

    function automatic void model_edge();
        t = t + 1;
        for (int c = 0; c < N; c++) begin
            bit ok;
            hist[c][t] = btn[c];
            if (clr) begin
                cw_m[c] = 0;
                cs_m[c] = 0;
            end else if (rise[c] == t - 2) begin
                cw_m[c] = (cw_m[c] + 1) % (1 << CW);
                if (cs_m[c] < (1 << CW) - 1) cs_m[c] = cs_m[c] + 1;
            end
            ok = 1'b1;
            for (int j = t - ST + 1; j <= t; j++) begin
                if (j <= lchg[c] || s_at(c, j) == db_m[c]) ok = 1'b0;
            end
            if (ok) begin
                db_m[c] = !db_m[c];
                lchg[c] = t;
                if (db_m[c]) rise[c] = t;
                else fall[c] = t;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic check();
        logic [N-1:0]    e_db, e_pulse, e_done;
        logic [N*CW-1:0] e_cw, e_cs;
        for (int c = 0; c < N; c++) begin
            e_db[c]    = db_m[c];
            e_pulse[c] = (rise[c] == t - 1);
            e_done[c]  = (rise[c] <= t - 2) && (fall[c] < rise[c] || fall[c] == t);
            e_cw[c*CW +: CW] = CW'(cw_m[c]);
            e_cs[c*CW +: CW] = CW'(cs_m[c]);
        end
        chk("db_level",    32'(w_db),    32'(e_db));
        chk("press_pulse", 32'(w_pulse), 32'(e_pulse));
        chk("done_sig",    32'(w_done),  32'(e_done));
        chk("any_done",    32'(w_any),   32'(|e_done));
        chk("count_wrap",  32'(w_cnt),   32'(e_cw));
        chk("sat_db",      32'(s_db),    32'(e_db));
        chk("sat_pulse",   32'(s_pulse), 32'(e_pulse));
        chk("sat_done",    32'(s_done),  32'(e_done));
        chk("sat_any",     32'(s_any),   32'(|e_done));
        chk("count_sat",   32'(s_cnt),   32'(e_cs));
    endtask

    task automatic step();
        @(posedge clk_div);
        if (!rst) model_edge();
        #1 check();
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    // Asynchronous reset pulse: outputs must clear before any clock edge.
    task automatic do_reset(input int n);
        @(negedge clk_div);
        #1 rst = 1'b1;
        model_reset();
        #1 check();
        hold(n);
        @(negedge clk_div);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        btn = 4'hF;
        #2 check();
        hold(5);
        btn = '0;
        @(negedge clk_div);
        rst = 1'b0;
        hold(4);

        btn[0] = 1'b1; hold(20);
        btn[0] = 1'b0; hold(20);

        repeat (5) begin
            btn[1] = 1'b1; hold(3);
            btn[1] = 1'b0; hold(3);
        end
        hold(6);

        repeat (17) begin
            btn[2] = 1'b1; hold(8);
            btn[2] = 1'b0; hold(8);
        end

        btn = 4'hF; hold(12);
        btn = 4'h0; hold(12);
        btn = 4'hF;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rise[0] == t - 1) break;
        end
        clr = 1'b1; step();
        clr = 1'b0; hold(10);
        btn = 4'h0; hold(12);
        btn = 4'hF; hold(12);
        btn = 4'h0; hold(12);

        repeat (2) begin
            btn[3] = 1'b1; hold(10);
            btn[3] = 1'b0; hold(10);
        end
        btn[3] = 1'b1; hold(12);
        do_reset(3);
        hold(15);
        btn[3] = 1'b0; hold(12);

        for (int c = 0; c < N; c++) runlen[c] = $urandom_range(1, 10);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (runlen[c] == 0) begin
                    btn[c]    = ~btn[c];
                    runlen[c] = $urandom_range(1, 10);
                end else begin
                    runlen[c] = runlen[c] - 1;
                end
            end
            clr = ($urandom_range(0, 49) == 0);
            if (cyc == 1500) do_reset($urandom_range(1, 4));
            step();
        end
        clr = 1'b0;
        btn = '0;
        hold(12);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
